// File: rtl/mem_writeback.sv
// mem_writeback: memory-access and write-back stage of the multi-cycle 8-bit core.
//   - Reads the internal data memory for LW during the MEM phase.
//   - Owns the 32x8 register file: it is written on the WB edge and read through rsv/rtv.
//   - Reports each register write on wb_valid/wb_reg/wb_data, raises a sticky
//     mem_fault for out-of-range LW addresses, and counts retired instructions.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   state                             core phase (IF=0, ID=1, EX=2, MEM=3, WB=4)
//   opcode, func                      decoded instruction fields
//   rs_addr, rt_addr, rd_addr         register addresses (rt is also the I-form destination)
//   data_addr, result                 LW address and ALU/link result from execute
//   instruction_invalid               execute rejected the instruction
//   init_we, init_addr, init_data     data memory preload port (honoured only in IF)
//   rsv, rtv                          combinational register reads (register 0 reads 0)
//   wb_valid, wb_reg, wb_data         write-back report
//   mem_fault                         sticky out-of-range LW flag
//   retire_count                      saturating count of retired valid instructions
module mem_writeback #(
    parameter int DMEM_DEPTH = 16,
    parameter int RF_LINK    = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  state,
    input  logic [5:0]  opcode,
    input  logic [5:0]  func,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    input  logic [7:0]  data_addr,
    input  logic [7:0]  result,
    input  logic        instruction_invalid,
    input  logic        init_we,
    input  logic [7:0]  init_addr,
    input  logic [7:0]  init_data,
    output logic [7:0]  rsv,
    output logic [7:0]  rtv,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [7:0]  wb_data,
    output logic        mem_fault,
    output logic [15:0] retire_count
);

    localparam logic [2:0] STATE_IF  = 3'd0;
    localparam logic [2:0] STATE_MEM = 3'd3;
    localparam logic [2:0] STATE_WB  = 3'd4;

    // JR, BEQ and BNE need no decode here: they fall into the no-write default.
    localparam logic [5:0] OP_RFORM = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h17;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam int         AW         = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
    localparam logic [8:0] DMEM_LIMIT = 9'(DMEM_DEPTH);

    logic [7:0] dmem [DMEM_DEPTH];
    logic [7:0] regs [32];
    logic [7:0] mdr;
    logic       lw_fault;   // the most recent valid LW faulted; gates its write-back

    logic       addr_ok;
    logic       init_ok;
    logic       wb_fire;
    logic       wr_en;
    logic [4:0] wr_dest;
    logic [7:0] wr_data;

    assign addr_ok = ({1'b0, data_addr} < DMEM_LIMIT);
    assign init_ok = ({1'b0, init_addr} < DMEM_LIMIT);

    assign rsv = (rs_addr == 5'd0) ? 8'h00 : regs[rs_addr];
    assign rtv = (rt_addr == 5'd0) ? 8'h00 : regs[rt_addr];

    // NOTE: the data memory has no reset so its contents survive rst_n and it
    // can map onto a plain RAM; the register file is small enough to clear.
    always_ff @(posedge clk) begin
        if (state == STATE_IF && init_we && init_ok)
            dmem[init_addr[AW-1:0]] <= init_data;
    end

    // Destination select. Every output gets a default first so the decode
    // never holds a previous value.
    // NOTE: defaults at the top of always_comb are what prevent latch inference.
    always_comb begin
        wr_dest = 5'd0;
        wr_data = 8'h00;
        case (opcode)
            OP_ADDIU: begin
                wr_dest = rt_addr;
                wr_data = result;
            end
            OP_RFORM: begin
                if (func == FN_ADDU || func == FN_SLT) begin
                    wr_dest = rd_addr;
                    wr_data = result;
                end
            end
            OP_LW: begin
                if (!lw_fault) begin
                    wr_dest = rt_addr;
                    wr_data = mdr;
                end
            end
            OP_JAL: begin
                wr_dest = 5'(RF_LINK);
                wr_data = result;
            end
            default: ;
        endcase
    end

    assign wb_fire = (state == STATE_WB) && !instruction_invalid;
    assign wr_en   = wb_fire && (wr_dest != 5'd0);

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
            mdr          <= 8'h00;
            lw_fault     <= 1'b0;
            wb_valid     <= 1'b0;
            wb_reg       <= 5'd0;
            wb_data      <= 8'h00;
            mem_fault    <= 1'b0;
            retire_count <= 16'h0000;
        end else begin
            wb_valid <= 1'b0;

            if (state == STATE_MEM && opcode == OP_LW && !instruction_invalid) begin
                if (addr_ok) begin
                    mdr      <= dmem[data_addr[AW-1:0]];
                    lw_fault <= 1'b0;
                end else begin
                    mdr       <= 8'h00;
                    lw_fault  <= 1'b1;
                    mem_fault <= 1'b1;
                end
            end

            if (wb_fire) begin
                if (retire_count != 16'hFFFF)
                    retire_count <= retire_count + 16'd1;
                if (wr_en) begin
                    regs[wr_dest] <= wr_data;
                    wb_valid      <= 1'b1;
                    wb_reg        <= wr_dest;
                    wb_data       <= wr_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_writeback.sv
module tb_mem_writeback;

    localparam logic [2:0] S_IF = 3'd0, S_ID = 3'd1, S_EX = 3'd2, S_MEM = 3'd3, S_WB = 3'd4;
    localparam logic [5:0] RF = 6'h00, JAL = 6'h03, BEQ = 6'h04, BNE = 6'h05,
                           ADDIU = 6'h09, LW = 6'h17, BAD = 6'h3F;
    localparam logic [5:0] F_ADDU = 6'h21, F_SLT = 6'h2A, F_JR = 6'h08;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  state;
    logic [5:0]  opcode, func;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic [7:0]  data_addr, result;
    logic        instruction_invalid;
    logic        init_we;
    logic [7:0]  init_addr, init_data;
    logic [7:0]  rsv, rtv;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [7:0]  wb_data;
    logic        mem_fault;
    logic [15:0] retire_count;

    int n_pass  = 0;
    int n_total = 0;

    mem_writeback #(.DMEM_DEPTH(16), .RF_LINK(31)) dut (
        .clk(clk), .rst_n(rst_n), .state(state), .opcode(opcode), .func(func),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
        .data_addr(data_addr), .result(result),
        .instruction_invalid(instruction_invalid),
        .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
        .rsv(rsv), .rtv(rtv), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .wb_data(wb_data), .mem_fault(mem_fault), .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic step(input logic [2:0] s);
        state = s;
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [7:0] d, input logic [2:0] s);
        init_we   = 1'b1;
        init_addr = a;
        init_data = d;
        step(s);
        init_we   = 1'b0;
    endtask

    task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [7:0] da, input logic [7:0] res,
                             input logic inv);
        opcode = op; func = fn; rt_addr = rt; rd_addr = rd;
        data_addr = da; result = res; instruction_invalid = inv;
    endtask

    // Walks one instruction IF..WB; returns one time unit after the WB edge.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt,
                             input logic [4:0] rd, input logic [7:0] da, input logic [7:0] res,
                             input logic inv);
        set_instr(op, fn, rt, rd, da, res, inv);
        step(S_IF); step(S_ID); step(S_EX); step(S_MEM); step(S_WB);
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [7:0]  da;
        logic [7:0]  res;
        logic        inv;
        logic        e_wbv;
        logic [4:0]  e_reg;
        logic [7:0]  e_data;
        logic        e_fault;
        logic [15:0] e_ret;
    } vec_t;

    vec_t vecs[10];

    typedef struct {
        logic [4:0] a;
        logic [7:0] v;
    } rd_t;

    rd_t reads[9];

    // Reference model state for the randomized phase.
    logic [7:0]  m_regs [32];
    logic [7:0]  m_dmem [16];
    logic        m_fault;
    int          m_retire;
    logic [4:0]  m_wb_reg;
    logic [7:0]  m_wb_data;

    initial begin
        rst_n = 1'b0; state = S_IF; init_we = 1'b0; init_addr = '0; init_data = '0;
        rs_addr = '0;
        set_instr(RF, 6'h00, 5'd0, 5'd0, 8'h00, 8'h00, 1'b0);

        #12;
        check("reset_wb_valid", 32'(wb_valid), 0);
        check("reset_retire", 32'(retire_count), 0);
        check("reset_fault", 32'(mem_fault), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Preload through IF; an out-of-range preload is ignored.
        preload(8'd10, 8'h37, S_IF);
        preload(8'd3,  8'h5A, S_IF);
        preload(8'h20, 8'hEE, S_IF);

        //          op     fn      rt     rd     da     res    inv  wbv reg    data   flt ret
        vecs[0] = '{ADDIU, 6'h00,  5'd2,  5'd0,  8'h00, 8'h2A, 0,   1,  5'd2,  8'h2A, 0,  16'd1};
        vecs[1] = '{LW,    6'h00,  5'd1,  5'd0,  8'd10, 8'h00, 0,   1,  5'd1,  8'h37, 0,  16'd2};
        vecs[2] = '{LW,    6'h00,  5'd3,  5'd0,  8'h20, 8'h00, 0,   0,  5'd1,  8'h37, 1,  16'd3};
        vecs[3] = '{RF,    F_ADDU, 5'd10, 5'd0,  8'h00, 8'hFF, 0,   0,  5'd1,  8'h37, 1,  16'd4};
        vecs[4] = '{JAL,   6'h00,  5'd0,  5'd0,  8'h00, 8'h0E, 0,   1,  5'd31, 8'h0E, 1,  16'd5};
        vecs[5] = '{ADDIU, 6'h00,  5'd4,  5'd0,  8'h00, 8'h99, 1,   0,  5'd31, 8'h0E, 1,  16'd5};
        vecs[6] = '{BEQ,   6'h00,  5'd6,  5'd0,  8'h00, 8'h55, 0,   0,  5'd31, 8'h0E, 1,  16'd6};
        vecs[7] = '{RF,    F_SLT,  5'd12, 5'd5,  8'h00, 8'h01, 0,   1,  5'd5,  8'h01, 1,  16'd7};
        vecs[8] = '{RF,    F_JR,   5'd0,  5'd6,  8'h00, 8'h44, 0,   0,  5'd5,  8'h01, 1,  16'd8};
        vecs[9] = '{LW,    6'h00,  5'd7,  5'd0,  8'd3,  8'h00, 1,   0,  5'd5,  8'h01, 1,  16'd8};

        for (int i = 0; i < 10; i++) begin
            run_instr(vecs[i].op, vecs[i].fn, vecs[i].rt, vecs[i].rd,
                      vecs[i].da, vecs[i].res, vecs[i].inv);
            check($sformatf("vec%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].e_wbv));
            check($sformatf("vec%0d_wb_reg", i), 32'(wb_reg), 32'(vecs[i].e_reg));
            check($sformatf("vec%0d_wb_data", i), 32'(wb_data), 32'(vecs[i].e_data));
            check($sformatf("vec%0d_fault", i), 32'(mem_fault), 32'(vecs[i].e_fault));
            check($sformatf("vec%0d_retire", i), 32'(retire_count), 32'(vecs[i].e_ret));
        end

        reads[0] = '{5'd2, 8'h2A};  reads[1] = '{5'd1, 8'h37};  reads[2] = '{5'd3, 8'h00};
        reads[3] = '{5'd0, 8'h00};  reads[4] = '{5'd31, 8'h0E}; reads[5] = '{5'd4, 8'h00};
        reads[6] = '{5'd5, 8'h01};  reads[7] = '{5'd6, 8'h00};  reads[8] = '{5'd7, 8'h00};
        for (int i = 0; i < 9; i++) begin
            rs_addr = reads[i].a;
            rt_addr = reads[i].a;
            #1;
            check($sformatf("reg%0d_rsv", reads[i].a), 32'(rsv), 32'(reads[i].v));
            check($sformatf("reg%0d_rtv", reads[i].a), 32'(rtv), 32'(reads[i].v));
        end

        // Preload outside IF is ignored, then LW latency: the MEM edge alone
        // does not touch the register file, the WB edge does.
        preload(8'd3, 8'hFF, S_EX);
        set_instr(LW, 6'h00, 5'd8, 5'd0, 8'd3, 8'h00, 1'b0);
        step(S_IF); step(S_ID); step(S_EX); step(S_MEM);
        check("lw_before_wb", 32'(rtv), 32'h00);
        step(S_WB);
        check("lw_gated_preload", 32'(rtv), 32'h5A);
        check("lw_wb_valid", 32'(wb_valid), 1);
        step(S_IF);
        check("wb_valid_one_cycle", 32'(wb_valid), 0);
        check("wb_reg_hold", 32'(wb_reg), 8);
        check("wb_data_hold", 32'(wb_data), 32'h5A);

        // Reset asserted during the WB phase discards the pending write.
        set_instr(ADDIU, 6'h00, 5'd9, 5'd0, 8'h00, 8'h77, 1'b0);
        step(S_IF); step(S_ID); step(S_EX); step(S_MEM);
        state = S_WB;
        rst_n = 1'b0;
        @(posedge clk); #1;
        state = S_IF;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rs_addr = 5'd2; rt_addr = 5'd9; #1;
        check("rst_reg2", 32'(rsv), 0);
        check("rst_reg9", 32'(rtv), 0);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_retire", 32'(retire_count), 0);
        check("rst_fault", 32'(mem_fault), 0);
        check("rst_wb_reg", 32'(wb_reg), 0);

        // Data memory survives reset.
        run_instr(LW, 6'h00, 5'd1, 5'd0, 8'd10, 8'h00, 1'b0);
        check("dmem_kept", 32'(rtv), 32'h37);

        // Randomized phase against the reference model.
        for (int i = 0; i < 32; i++) m_regs[i] = 8'h00;
        m_regs[1] = 8'h37;
        m_fault   = 1'b0;
        m_retire  = 1;
        m_wb_reg  = 5'd1;
        m_wb_data = 8'h37;
        for (int a = 0; a < 16; a++) begin
            m_dmem[a] = 8'($urandom);
            preload(8'(a), m_dmem[a], S_IF);
        end

        for (int n = 0; n < 200; n++) begin
            int         k;
            logic [5:0] op, fn;
            logic [4:0] rt, rd, dest;
            logic [7:0] da, res, val;
            logic       inv, e_wbv;

            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] pa, pd;
                pa = 8'($urandom_range(0, 20));
                pd = 8'($urandom);
                preload(pa, pd, S_IF);
                if (pa < 16) m_dmem[pa[3:0]] = pd;
            end

            k   = $urandom_range(0, 9);
            rt  = 5'($urandom);
            rd  = 5'($urandom);
            da  = 8'($urandom_range(0, 19));
            res = 8'($urandom);
            inv = ($urandom_range(0, 9) == 0);
            fn  = 6'($urandom);
            case (k)
                0, 1:    op = ADDIU;
                2:       begin op = RF; fn = F_ADDU; end
                3:       begin op = RF; fn = F_SLT; end
                4:       begin op = RF; fn = F_JR; end
                5, 6:    op = LW;
                7:       op = JAL;
                8:       op = ($urandom_range(0, 1) == 0) ? BEQ : BNE;
                default: op = BAD;
            endcase

            dest = 5'd0;
            val  = 8'h00;
            if (!inv) begin
                m_retire++;
                if (op == ADDIU) begin dest = rt; val = res; end
                else if (op == RF && (fn == F_ADDU || fn == F_SLT)) begin dest = rd; val = res; end
                else if (op == JAL) begin dest = 5'd31; val = res; end
                else if (op == LW) begin
                    if (da >= 16) m_fault = 1'b1;
                    else begin dest = rt; val = m_dmem[da[3:0]]; end
                end
            end
            e_wbv = (dest != 5'd0);
            if (e_wbv) begin
                m_regs[dest] = val;
                m_wb_reg     = dest;
                m_wb_data    = val;
            end

            run_instr(op, fn, rt, rd, da, res, inv);
            check($sformatf("rnd%0d_wb_valid", n), 32'(wb_valid), 32'(e_wbv));
            check($sformatf("rnd%0d_wb_reg", n), 32'(wb_reg), 32'(m_wb_reg));
            check($sformatf("rnd%0d_wb_data", n), 32'(wb_data), 32'(m_wb_data));
            check($sformatf("rnd%0d_fault", n), 32'(mem_fault), 32'(m_fault));
            check($sformatf("rnd%0d_retire", n), 32'(retire_count), m_retire);
            rs_addr = 5'($urandom);
            rt_addr = 5'($urandom);
            #1;
            check($sformatf("rnd%0d_rsv", n), 32'(rsv), 32'(m_regs[rs_addr]));
            check($sformatf("rnd%0d_rtv", n), 32'(rtv), 32'(m_regs[rt_addr]));
        end

        // Saturation: hold WB with a retiring, non-writing instruction.
        set_instr(BEQ, 6'h00, 5'd0, 5'd0, 8'h00, 8'h00, 1'b0);
        state = S_WB;
        repeat (65600 - m_retire) @(posedge clk);
        #1;
        check("retire_saturate", 32'(retire_count), 32'hFFFF);
        step(S_WB);
        check("retire_hold", 32'(retire_count), 32'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
